// File: rtl/reduction_stream_scheduler.sv
// Packet-granular round-robin scheduler feeding one reduction datapath; tag FIFOs route the
// echoed stream and each packet's final running-max back to the requester that issued it.
module reduction_stream_scheduler #(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 512,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      s_valid,
  output logic [N_REQ-1:0]      s_ready,
  input  logic [N_REQ*DATA_W-1:0] s_data,
  input  logic [N_REQ-1:0]      s_last,
  output logic                  dp_in_valid,
  input  logic                  dp_in_ready,
  output logic [DATA_W-1:0]     dp_in_data,
  output logic                  dp_in_last,
  input  logic                  dp_out_valid,
  output logic                  dp_out_ready,
  input  logic [DATA_W-1:0]     dp_out_data,
  input  logic                  dp_out_last,
  input  logic                  dp_res_valid,
  input  logic [63:0]           dp_res_data,
  input  logic                  dp_res_last,
  output logic [N_REQ-1:0]      m_valid,
  input  logic [N_REQ-1:0]      m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_last,
  output logic [N_REQ-1:0]      res_valid,
  output logic [N_REQ*64-1:0]   res_max,
  output logic                  err_orphan
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // TAG_DEPTH must be a power of two of at least 2 for the extra-MSB full/empty scheme.
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              r_state;
  logic [GW-1:0]       r_grant;
  logic [GW-1:0]       r_rr;
  logic [GW-1:0]       r_tag_mem  [TAG_DEPTH];
  logic [PW-1:0]       r_tag_wr;
  logic [PW-1:0]       r_tag_rd;
  logic [GW-1:0]       r_rtag_mem [TAG_DEPTH];
  logic [PW-1:0]       r_rtag_wr;
  logic [PW-1:0]       r_rtag_rd;
  logic [N_REQ*64-1:0] r_res_max;
  logic [N_REQ-1:0]    r_res_valid;
  logic                r_err_orphan;

  logic          w_pick_found;
  logic [GW-1:0] w_pick;
  logic          w_tag_empty;
  logic          w_tag_full;
  logic [GW-1:0] w_tag_head;
  logic          w_rtag_empty;
  logic          w_rtag_full;
  logic [GW-1:0] w_rtag_head;
  logic          w_grant_fire;
  logic          w_beat_last;
  logic          w_tag_pop;
  logic          w_res_fire;
  logic          w_rtag_pop;
  logic          w_rtag_push;

  assign w_tag_empty  = (r_tag_wr == r_tag_rd);
  assign w_tag_full   = (r_tag_wr[AW] != r_tag_rd[AW]) && (r_tag_wr[AW-1:0] == r_tag_rd[AW-1:0]);
  assign w_tag_head   = r_tag_mem[r_tag_rd[AW-1:0]];
  assign w_rtag_empty = (r_rtag_wr == r_rtag_rd);
  assign w_rtag_full  = (r_rtag_wr[AW] != r_rtag_rd[AW]) && (r_rtag_wr[AW-1:0] == r_rtag_rd[AW-1:0]);
  assign w_rtag_head  = r_rtag_mem[r_rtag_rd[AW-1:0]];

  // Scan downward so the requester closest to (at or after) r_rr wins.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (s_valid[(int'(r_rr) + k) % N_REQ]) begin
        w_pick_found = 1'b1;
        w_pick       = GW'((int'(r_rr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    s_ready     = '0;
    dp_in_valid = 1'b0;
    dp_in_data  = s_data[int'(r_grant)*DATA_W +: DATA_W];
    dp_in_last  = s_last[r_grant];
    if (r_state == BUSY) begin
      dp_in_valid      = s_valid[r_grant];
      s_ready[r_grant] = dp_in_ready;
    end
  end

  always_comb begin
    m_valid      = '0;
    dp_out_ready = 1'b0;
    m_data       = dp_out_data;
    m_last       = dp_out_last;
    if (!w_tag_empty) begin
      m_valid[w_tag_head] = dp_out_valid;
      dp_out_ready        = m_ready[w_tag_head];
    end
  end

  assign w_grant_fire = (r_state == IDLE) && w_pick_found && !w_tag_full;
  assign w_beat_last  = (r_state == BUSY) && dp_in_valid && dp_in_ready && dp_in_last;
  assign w_tag_pop    = dp_out_valid && dp_out_ready && dp_out_last;
  assign w_res_fire   = dp_res_valid && dp_res_last;
  assign w_rtag_pop   = w_res_fire && !w_rtag_empty;
  // A grant while the result-tag FIFO is full loses that packet's result routing.
  assign w_rtag_push  = w_grant_fire && !w_rtag_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_rr         <= '0;
      r_tag_wr     <= '0;
      r_tag_rd     <= '0;
      r_rtag_wr    <= '0;
      r_rtag_rd    <= '0;
      r_res_max    <= '0;
      r_res_valid  <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_res_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_grant_fire) begin
            r_grant <= w_pick;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_beat_last) begin
            r_state <= IDLE;
            r_rr    <= (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_grant_fire) begin
        r_tag_mem[r_tag_wr[AW-1:0]] <= w_pick;
        r_tag_wr                    <= r_tag_wr + 1'b1;
      end
      if (w_tag_pop) begin
        r_tag_rd <= r_tag_rd + 1'b1;
      end
      if (w_rtag_push) begin
        r_rtag_mem[r_rtag_wr[AW-1:0]] <= w_pick;
        r_rtag_wr                     <= r_rtag_wr + 1'b1;
      end
      if (w_rtag_pop) begin
        r_rtag_rd                              <= r_rtag_rd + 1'b1;
        r_res_max[int'(w_rtag_head)*64 +: 64]  <= dp_res_data;
        r_res_valid[w_rtag_head]               <= 1'b1;
      end
      if (w_res_fire && w_rtag_empty) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  assign res_max    = r_res_max;
  assign res_valid  = r_res_valid;
  assign err_orphan = r_err_orphan;

endmodule

// File: tb/tb_reduction_stream_scheduler.sv
// Scoreboard bench for reduction_stream_scheduler: the bench plays requesters and datapath,
// queues expected dp_in beats, echo routing and results, and a negedge monitor checks them.
module tb_reduction_stream_scheduler;

  localparam int N_REQ     = 2;
  localparam int DATA_W    = 512;
  localparam int TAG_DEPTH = 4;

  logic                    clock;
  logic                    reset;
  logic [N_REQ-1:0]        s_valid;
  logic [N_REQ-1:0]        s_ready;
  logic [N_REQ*DATA_W-1:0] s_data;
  logic [N_REQ-1:0]        s_last;
  logic                    dp_in_valid;
  logic                    dp_in_ready;
  logic [DATA_W-1:0]       dp_in_data;
  logic                    dp_in_last;
  logic                    dp_out_valid;
  logic                    dp_out_ready;
  logic [DATA_W-1:0]       dp_out_data;
  logic                    dp_out_last;
  logic                    dp_res_valid;
  logic [63:0]             dp_res_data;
  logic                    dp_res_last;
  logic [N_REQ-1:0]        m_valid;
  logic [N_REQ-1:0]        m_ready;
  logic [DATA_W-1:0]       m_data;
  logic                    m_last;
  logic [N_REQ-1:0]        res_valid;
  logic [N_REQ*64-1:0]     res_max;
  logic                    err_orphan;

  reduction_stream_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready), .dp_in_data(dp_in_data),
    .dp_in_last(dp_in_last),
    .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready), .dp_out_data(dp_out_data),
    .dp_out_last(dp_out_last),
    .dp_res_valid(dp_res_valid), .dp_res_data(dp_res_data), .dp_res_last(dp_res_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .res_valid(res_valid), .res_max(res_max), .err_orphan(err_orphan)
  );

  typedef struct packed { logic [DATA_W-1:0] data; logic last; } beat_t;
  typedef struct packed { int idx; logic [DATA_W-1:0] data; logic last; } ret_t;
  typedef struct packed { int idx; logic [63:0] val; } res_t;

  beat_t       txq0[$];
  beat_t       txq1[$];
  beat_t       expIn[$];
  ret_t        expRet[$];
  res_t        expRes[$];
  logic [63:0] expMax [N_REQ];
  int          checks = 0;
  int          errors = 0;
  int          inAcc  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] makeData(input int r, input int p, input int b);
    logic [31:0] w;
    w = 32'(r * 65536 + p * 256 + b);
    return {(DATA_W/32){w}};
  endfunction

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input int pkt, input int nBeats);
    beat_t b;
    for (int i = 0; i < nBeats; i++) begin
      b.data = makeData(idx, pkt, i);
      b.last = (i == nBeats - 1);
      if (idx == 0) txq0.push_back(b);
      else          txq1.push_back(b);
    end
  endtask

  task automatic expectPacket(input int idx, input int pkt, input int nBeats);
    beat_t b;
    for (int i = 0; i < nBeats; i++) begin
      b.data = makeData(idx, pkt, i);
      b.last = (i == nBeats - 1);
      expIn.push_back(b);
    end
  endtask

  // Each requester presents the head of its queue and drops it once a handshake was seen.
  task automatic driveReq(input int idx);
    logic  acc;
    logic  have;
    beat_t b;
    forever begin
      @(negedge clock);
      acc = s_valid[idx] && s_ready[idx];
      @(posedge clock);
      #1;
      if (acc) begin
        if (idx == 0 && txq0.size() > 0) b = txq0.pop_front();
        if (idx == 1 && txq1.size() > 0) b = txq1.pop_front();
      end
      have = (idx == 0) ? (txq0.size() > 0) : (txq1.size() > 0);
      if (have) begin
        b = (idx == 0) ? txq0[0] : txq1[0];
        s_valid[idx]                 = 1'b1;
        s_data[idx*DATA_W +: DATA_W] = b.data;
        s_last[idx]                  = b.last;
      end else begin
        s_valid[idx] = 1'b0;
      end
    end
  endtask

  initial driveReq(0);
  initial driveReq(1);

  always @(negedge clock) begin : monitor
    beat_t            eb;
    ret_t             er;
    res_t             es;
    logic [N_REQ-1:0] oh;
    if (!reset) begin
      if (dp_in_valid && dp_in_ready) begin
        inAcc++;
        if (expIn.size() == 0) begin
          checkOutput("dp_in_unexpected", {dp_in_data[DATA_W-2:0], dp_in_last}, '0);
        end else begin
          eb = expIn.pop_front();
          checkOutput("dp_in_beat", {dp_in_data, dp_in_last}, {eb.data, eb.last});
        end
      end
      if (dp_out_valid && dp_out_ready) begin
        if (expRet.size() == 0) begin
          checkOutput("m_unexpected", DATA_W'(m_valid), '0);
        end else begin
          er = expRet.pop_front();
          oh = '0;
          oh[er.idx] = 1'b1;
          checkOutput("m_valid_route", DATA_W'(m_valid), DATA_W'(oh));
          checkOutput("m_beat", {m_data, m_last}, {er.data, er.last});
        end
      end
      if (res_valid != '0) begin
        if (expRes.size() == 0) begin
          checkOutput("res_unexpected", DATA_W'(res_valid), '0);
        end else begin
          es = expRes.pop_front();
          oh = '0;
          oh[es.idx] = 1'b1;
          checkOutput("res_valid_pulse", DATA_W'(res_valid), DATA_W'(oh));
          checkOutput("res_max_value", DATA_W'(res_max[es.idx*64 +: 64]), DATA_W'(es.val));
        end
      end
    end
  end

  task automatic waitInDone(input string name, input int budget);
    int n = 0;
    while (expIn.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, DATA_W'(expIn.size()), '0);
  endtask

  task automatic returnBeat(input int idx, input logic [DATA_W-1:0] d, input logic l);
    ret_t r;
    logic done = 1'b0;
    int   n    = 0;
    r.idx = idx; r.data = d; r.last = l;
    expRet.push_back(r);
    dp_out_valid = 1'b1;
    dp_out_data  = d;
    dp_out_last  = l;
    while (!done && n < 50) begin
      @(negedge clock);
      done = dp_out_ready;
      tick();
      n++;
    end
    dp_out_valid = 1'b0;
    checkOutput("return_accepted", DATA_W'(done), DATA_W'(1));
    if (!done) r = expRet.pop_back();
  endtask

  task automatic sendRes(input logic [63:0] val, input logic l, input int expIdx);
    res_t r;
    dp_res_valid = 1'b1;
    dp_res_data  = val;
    dp_res_last  = l;
    if (expIdx >= 0) begin
      r.idx = expIdx; r.val = val;
      expRes.push_back(r);
      expMax[expIdx] = val;
    end
    tick();
    dp_res_valid = 1'b0;
    dp_res_last  = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    @(negedge clock);
    checkOutput({tag, "_s_ready"}, DATA_W'(s_ready), '0);
    checkOutput({tag, "_m_valid"}, DATA_W'(m_valid), '0);
    checkOutput({tag, "_dp_in_valid"}, DATA_W'(dp_in_valid), '0);
    checkOutput({tag, "_res_valid"}, DATA_W'(res_valid), '0);
    checkOutput({tag, "_res_max"}, DATA_W'(res_max), '0);
    checkOutput({tag, "_err_orphan"}, DATA_W'(err_orphan), '0);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    reset = 1'b1; s_valid = '0; s_data = '0; s_last = '0;
    dp_in_ready = 1'b1; dp_out_valid = 1'b0; dp_out_data = '0; dp_out_last = 1'b0;
    dp_res_valid = 1'b0; dp_res_data = '0; dp_res_last = 1'b0; m_ready = '1;
    for (int i = 0; i < N_REQ; i++) expMax[i] = '0;
    tick(); tick();
    checkResetState("reset");
    reset = 1'b0;
    tick();

    // Single 3-beat packet from requester 1, echoed and reduced to 0x2A.
    @(negedge clock); #1;
    applyStimulus(1, 1, 3);
    expectPacket(1, 1, 3);
    waitInDone("single_in_done", 40);
    for (int b = 0; b < 3; b++) returnBeat(1, makeData(1, 1, b), b == 2);
    sendRes(64'h11, 1'b0, -1);
    sendRes(64'h2A, 1'b1, 1);
    repeat (3) tick();

    // Both requesters loaded: grants must alternate starting at requester 0.
    @(negedge clock); #1;
    applyStimulus(0, 10, 2); applyStimulus(0, 11, 2);
    applyStimulus(1, 20, 2); applyStimulus(1, 21, 2);
    expectPacket(0, 10, 2); expectPacket(1, 20, 2);
    expectPacket(0, 11, 2); expectPacket(1, 21, 2);
    waitInDone("fair_in_done", 60);
    returnBeat(0, makeData(0, 10, 1), 1'b1);
    returnBeat(1, makeData(1, 20, 1), 1'b1);
    returnBeat(0, makeData(0, 11, 1), 1'b1);
    returnBeat(1, makeData(1, 21, 1), 1'b1);
    sendRes(64'h100, 1'b1, 0);
    sendRes(64'h80, 1'b1, 1);
    sendRes(64'h300, 1'b1, 0);
    sendRes(64'h5, 1'b1, 1);
    repeat (3) tick();

    // dp_in_ready toggles while a 4-beat packet streams; s_ready must follow it.
    @(negedge clock); #1;
    applyStimulus(0, 30, 4);
    expectPacket(0, 30, 4);
    fork
      begin
        for (int c = 0; c < 16; c++) begin
          dp_in_ready = (c % 2 == 0);
          @(negedge clock);
          if (dp_in_valid) checkOutput("bp_s_ready", DATA_W'(s_ready), DATA_W'({1'b0, dp_in_ready}));
          tick();
        end
        dp_in_ready = 1'b1;
      end
      waitInDone("bp_in_done", 40);
    join
    returnBeat(0, makeData(0, 30, 3), 1'b1);
    sendRes(64'h77, 1'b1, 0);
    repeat (3) tick();

    // Echo path stalled: four packets fill the tag FIFO, the fifth waits for one pop.
    m_ready = '0;
    base = inAcc;
    @(negedge clock); #1;
    applyStimulus(1, 40, 1); applyStimulus(0, 41, 1); applyStimulus(1, 42, 1);
    applyStimulus(0, 43, 1); applyStimulus(1, 44, 1);
    expectPacket(1, 40, 1); expectPacket(0, 41, 1); expectPacket(1, 42, 1);
    expectPacket(0, 43, 1); expectPacket(1, 44, 1);
    n = 0;
    while (inAcc - base < 4 && n < 60) begin
      tick();
      n++;
    end
    repeat (6) tick();
    checkOutput("tagfull_grants", DATA_W'(inAcc - base), DATA_W'(4));
    @(negedge clock);
    checkOutput("tagfull_s_ready", DATA_W'(s_ready), '0);
    checkOutput("tagfull_dp_in_valid", DATA_W'(dp_in_valid), '0);
    tick();
    sendRes(64'h140, 1'b1, 1);
    sendRes(64'h141, 1'b1, 0);
    sendRes(64'h142, 1'b1, 1);
    sendRes(64'h143, 1'b1, 0);
    m_ready = '1;
    returnBeat(1, makeData(1, 40, 0), 1'b1);
    waitInDone("tagfull_fifth_grant", 20);
    returnBeat(0, makeData(0, 41, 0), 1'b1);
    returnBeat(1, makeData(1, 42, 0), 1'b1);
    returnBeat(0, makeData(0, 43, 0), 1'b1);
    returnBeat(1, makeData(1, 44, 0), 1'b1);
    sendRes(64'h144, 1'b1, 1);
    repeat (3) tick();

    // Nothing outstanding: echo is blocked and a final result is an orphan.
    dp_out_valid = 1'b1;
    @(negedge clock);
    checkOutput("empty_dp_out_ready", DATA_W'(dp_out_ready), '0);
    checkOutput("empty_m_valid", DATA_W'(m_valid), '0);
    tick();
    dp_out_valid = 1'b0;
    sendRes(64'h99, 1'b0, -1);
    checkOutput("nonlast_no_orphan", DATA_W'(err_orphan), '0);
    sendRes(64'hDEAD, 1'b1, -1);
    checkOutput("orphan_set", DATA_W'(err_orphan), DATA_W'(1));
    checkOutput("orphan_res_max", DATA_W'(res_max), DATA_W'({expMax[1], expMax[0]}));
    repeat (5) tick();
    checkOutput("orphan_sticky", DATA_W'(err_orphan), DATA_W'(1));

    // Reset after beat 2 of 4, then a fresh packet from requester 1.
    @(negedge clock); #1;
    applyStimulus(1, 60, 4);
    expectPacket(1, 60, 4);
    base = inAcc;
    n = 0;
    while (inAcc - base < 2 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("midpkt_two_beats", DATA_W'(inAcc - base), DATA_W'(2));
    dp_in_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock); #1;
    txq1.delete();
    expIn.delete();
    tick();
    reset = 1'b0;
    dp_in_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) expMax[i] = '0;
    checkResetState("midreset");
    @(negedge clock); #1;
    applyStimulus(1, 61, 3);
    expectPacket(1, 61, 3);
    waitInDone("post_reset_in_done", 40);
    returnBeat(1, makeData(1, 61, 2), 1'b1);
    sendRes(64'h3C, 1'b1, 1);
    repeat (4) tick();

    checkOutput("exp_ret_drained", DATA_W'(expRet.size()), '0);
    checkOutput("exp_res_drained", DATA_W'(expRes.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
